// File: rtl/lif_neuron_update_pkg.sv
// Shared constants for the LIF neuron: fp32 field layout, NoC address width, FSM encoding.
package lif_neuron_update_pkg;

   localparam int          FP_W          = 32;
   localparam int          FP_EXP_W      = 8;
   localparam int          FP_MAN_W      = 23;
   localparam int          FP_SIGN_BIT   = 31;
   localparam int          FP_EXP_LSB    = 23;
   localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
   localparam int          NOC_ADDR_BITS = 12;
   localparam int          REFRAC_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAK  = 3'd1,
      ST_INTEG = 3'd2,
      ST_CHECK = 3'd3,
      ST_EMIT  = 3'd4
   } state_e;

   // Leading-zero count of a 27-bit mantissa+GRS word; 27 when all zero.
   function automatic logic [4:0] lzc27(input logic [26:0] x);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++)
         if (x[i]) lzc27 = 5'(26 - i);
   endfunction

endpackage

// File: rtl/lif_neuron_update_fp32_add.sv
// Combinational fp32 add/subtract: denormals flushed to zero, round-to-nearest-even,
// overflow saturates to signed infinity.
module fp32_add
   import lif_neuron_update_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   input  logic            sub,
   output logic [FP_W-1:0] result
);

   logic                w_sa, w_sb, w_sl, w_ss, w_swap, w_sticky, w_rnd_up;
   logic [FP_EXP_W-1:0] w_ea, w_eb, w_el, w_es, w_d;
   logic [23:0]         w_ma, w_mb, w_ml, w_ms;
   logic [26:0]         w_xs_sh, w_xs, w_mask, w_n;
   logic [27:0]         w_s28;
   logic [4:0]          w_lz;
   logic [24:0]         w_m25;
   logic signed [9:0]   w_en, w_ef;

   assign w_sa   = a[FP_SIGN_BIT];
   assign w_sb   = b[FP_SIGN_BIT] ^ sub;
   assign w_ea   = a[FP_EXP_LSB +: FP_EXP_W];
   assign w_eb   = b[FP_EXP_LSB +: FP_EXP_W];
   assign w_ma   = (w_ea == '0) ? 24'd0 : {1'b1, a[FP_MAN_W-1:0]};
   assign w_mb   = (w_eb == '0) ? 24'd0 : {1'b1, b[FP_MAN_W-1:0]};
   // Order operands by flushed magnitude so the subtract path never goes negative.
   assign w_swap = {w_eb, w_mb[22:0]} > {w_ea, w_ma[22:0]};
   assign w_sl   = w_swap ? w_sb : w_sa;
   assign w_ss   = w_swap ? w_sa : w_sb;
   assign w_el   = w_swap ? w_eb : w_ea;
   assign w_es   = w_swap ? w_ea : w_eb;
   assign w_ml   = w_swap ? w_mb : w_ma;
   assign w_ms   = w_swap ? w_ma : w_mb;

   assign w_d     = w_el - w_es;
   assign w_mask  = (w_d >= 8'd27) ? '1 : ((27'd1 << w_d) - 27'd1);
   assign w_xs_sh = (w_d >= 8'd27) ? '0 : ({w_ms, 3'b000} >> w_d);
   assign w_sticky = |({w_ms, 3'b000} & w_mask);
   assign w_xs    = {w_xs_sh[26:1], w_xs_sh[0] | w_sticky};

   always_comb begin
      w_s28 = '0;
      w_n   = '0;
      w_lz  = '0;
      w_en  = '0;
      if (w_sl == w_ss) begin
         w_s28 = {1'b0, w_ml, 3'b000} + {1'b0, w_xs};
         if (w_s28[27]) begin
            w_n  = {w_s28[27:2], w_s28[1] | w_s28[0]};
            w_en = $signed({2'b00, w_el}) + 10'sd1;
         end else begin
            w_n  = w_s28[26:0];
            w_en = $signed({2'b00, w_el});
         end
      end else begin
         w_s28 = {1'b0, w_ml, 3'b000} - {1'b0, w_xs};
         w_lz  = lzc27(w_s28[26:0]);
         w_n   = w_s28[26:0] << w_lz;
         w_en  = $signed({2'b00, w_el}) - $signed({5'b00000, w_lz});
      end
      w_rnd_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
      w_m25    = {1'b0, w_n[26:3]} + {24'd0, w_rnd_up};
      w_ef     = w_en + $signed({9'd0, w_m25[24]});

      if (w_ml == '0)
         result = {w_sl & w_ss, 31'd0};
      else if (w_n == '0)
         result = FP_ZERO;
      else if (w_ef >= 10'sd255)
         result = {w_sl, 8'hFF, 23'd0};
      else if (w_ef <= 10'sd0)
         result = {w_sl, 31'd0};
      else
         result = {w_sl, w_ef[7:0], w_m25[24] ? w_m25[23:1] : w_m25[22:0]};
   end

endmodule

// File: rtl/lif_neuron_update.sv
// Leaky integrate-and-fire neuron: leak, integrate, threshold once per accepted sum,
// then hold a spike toward the NoC until accepted.
module lif_neuron_update
   import lif_neuron_update_pkg::*;
#(
   parameter logic [NOC_ADDR_BITS-1:0] NEURON_ADDRESS = 12'd0,
   parameter logic [FP_W-1:0]          THRESHOLD      = 32'h42C8_0000,
   parameter logic [FP_W-1:0]          V_RESET        = 32'h0000_0000,
   parameter int                       LEAK_SHIFT     = 3,
   parameter int                       REFRAC_STEPS   = 2
)(
   input  logic                     CLK_Neuron,
   input  logic                     rst,
   input  logic [FP_W-1:0]          sum_in,
   input  logic                     sum_valid,
   output logic                     sum_ready,
   output logic [NOC_ADDR_BITS-1:0] spike_address,
   output logic                     spike_valid,
   input  logic                     spike_ready,
   output logic [FP_W-1:0]          potential,
   output logic                     refractory,
   output logic                     overrun
);

   state_e              r_state, w_state_nxt;
   logic [FP_W-1:0]     r_potential, w_pot_nxt;
   logic [FP_W-1:0]     r_sum, w_sum_nxt;
   logic [REFRAC_W-1:0] r_refrac_cnt, w_cnt_nxt;
   logic                r_overrun, w_ovr_nxt;

   logic [FP_EXP_W-1:0] w_v_exp;
   logic [FP_W-1:0]     w_leak_term, w_add_b, w_add_res;
   logic                w_add_sub, w_fire;

   // v*2^-LEAK_SHIFT by exponent decrement; anything that would go denormal becomes zero.
   assign w_v_exp     = r_potential[FP_EXP_LSB +: FP_EXP_W];
   assign w_leak_term = (w_v_exp <= 8'(LEAK_SHIFT))
                        ? {r_potential[FP_SIGN_BIT], 31'd0}
                        : {r_potential[FP_SIGN_BIT], w_v_exp - 8'(LEAK_SHIFT), r_potential[FP_MAN_W-1:0]};
   assign w_add_sub   = (r_state == ST_LEAK);
   assign w_add_b     = w_add_sub ? w_leak_term : r_sum;
   assign w_fire      = ~r_potential[FP_SIGN_BIT] && (r_potential[30:0] >= THRESHOLD[30:0]);

   fp32_add u_add (
      .a      (r_potential),
      .b      (w_add_b),
      .sub    (w_add_sub),
      .result (w_add_res)
   );

   always_ff @(posedge CLK_Neuron) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_potential  <= V_RESET;
         r_sum        <= FP_ZERO;
         r_refrac_cnt <= '0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_potential  <= w_pot_nxt;
         r_sum        <= w_sum_nxt;
         r_refrac_cnt <= w_cnt_nxt;
         r_overrun    <= w_ovr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pot_nxt     = r_potential;
      w_sum_nxt     = r_sum;
      w_cnt_nxt     = r_refrac_cnt;
      w_ovr_nxt     = r_overrun | (sum_valid & (r_state != ST_IDLE));
      sum_ready     = (r_state == ST_IDLE);
      spike_valid   = (r_state == ST_EMIT);
      spike_address = (r_state == ST_EMIT) ? NEURON_ADDRESS : '0;
      case (r_state)
         ST_IDLE: begin
            if (sum_valid) begin
               w_sum_nxt = sum_in;
               // Refractory timesteps consume the sum without touching the potential.
               if (r_refrac_cnt != '0) w_cnt_nxt = r_refrac_cnt - 1'b1;
               else                    w_state_nxt = ST_LEAK;
            end
         end
         ST_LEAK: begin
            w_pot_nxt   = w_add_res;
            w_state_nxt = ST_INTEG;
         end
         ST_INTEG: begin
            w_pot_nxt   = w_add_res;
            w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_fire) begin
               w_pot_nxt   = V_RESET;
               w_cnt_nxt   = REFRAC_W'(REFRAC_STEPS);
               w_state_nxt = ST_EMIT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (spike_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign potential  = r_potential;
   assign refractory = (r_refrac_cnt != '0);
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_lif_neuron_update.sv
// Directed bench for lif_neuron_update with hand-computed fp32 expectations.
module tb_lif_neuron_update;

   logic        clk = 1'b0;
   logic        rst, sum_valid, spike_ready;
   logic [31:0] sum_in;
   logic        sum_ready, spike_valid, refractory, overrun;
   logic [11:0] spike_address;
   logic [31:0] potential;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lif_neuron_update #(
      .NEURON_ADDRESS (12'd5),
      .THRESHOLD      (32'h42C8_0000),
      .V_RESET        (32'h0000_0000),
      .LEAK_SHIFT     (3),
      .REFRAC_STEPS   (2)
   ) dut (
      .CLK_Neuron    (clk),
      .rst           (rst),
      .sum_in        (sum_in),
      .sum_valid     (sum_valid),
      .sum_ready     (sum_ready),
      .spike_address (spike_address),
      .spike_valid   (spike_valid),
      .spike_ready   (spike_ready),
      .potential     (potential),
      .refractory    (refractory),
      .overrun       (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One-cycle sum pulse; returns at the negedge of the cycle after the transfer.
   task automatic send(input logic [31:0] v);
      sum_in    = v;
      sum_valid = 1'b1;
      @(negedge clk);
      sum_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sum_valid = 1'b0; spike_ready = 1'b1; sum_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_pot",   potential,             32'h0);
      chk("rst_sv",    {31'd0, spike_valid},  32'd0);
      chk("rst_addr",  {20'd0, spike_address},32'd0);
      chk("rst_rdy",   {31'd0, sum_ready},    32'd1);
      chk("rst_ref",   {31'd0, refractory},   32'd0);
      chk("rst_ovr",   {31'd0, overrun},      32'd0);

      // 50.0 from zero: no fire
      send(32'h4248_0000);
      chk("s1_busy",   {31'd0, sum_ready},    32'd0);
      repeat (2) @(negedge clk);
      chk("s1_pot",    potential,             32'h4248_0000);
      chk("s1_sv",     {31'd0, spike_valid},  32'd0);
      @(negedge clk);
      chk("s1_idle",   {31'd0, sum_ready},    32'd1);
      chk("s1_sv4",    {31'd0, spike_valid},  32'd0);

      // 60.0: 50 - 6.25 + 60 = 103.75 fires
      spike_ready = 1'b0;
      send(32'h4270_0000);
      repeat (2) @(negedge clk);
      chk("s2_pot3",   potential,             32'h42CF_8000);
      chk("s2_sv3",    {31'd0, spike_valid},  32'd0);
      @(negedge clk);
      chk("s2_sv",     {31'd0, spike_valid},  32'd1);
      chk("s2_addr",   {20'd0, spike_address},32'd5);
      chk("s2_pot",    potential,             32'h0);
      chk("s2_ref",    {31'd0, refractory},   32'd1);
      chk("s2_ovr0",   {31'd0, overrun},      32'd0);

      // Backpressure for 5 cycles with one stray sum pulse
      for (int i = 0; i < 5; i++) begin
         sum_valid = (i == 1);
         sum_in    = 32'h4120_0000;
         @(negedge clk);
      end
      sum_valid = 1'b0;
      chk("bp_sv",     {31'd0, spike_valid},  32'd1);
      chk("bp_rdy",    {31'd0, sum_ready},    32'd0);
      chk("bp_ovr",    {31'd0, overrun},      32'd1);
      chk("bp_pot",    potential,             32'h0);
      spike_ready = 1'b1;
      @(negedge clk);
      chk("acc_sv",    {31'd0, spike_valid},  32'd0);
      chk("acc_addr",  {20'd0, spike_address},32'd0);
      chk("acc_rdy",   {31'd0, sum_ready},    32'd1);

      // Refractory: two 200.0 sums ignored, third fires
      send(32'h4348_0000);
      chk("rf1_ref",   {31'd0, refractory},   32'd1);
      chk("rf1_pot",   potential,             32'h0);
      chk("rf1_rdy",   {31'd0, sum_ready},    32'd1);
      send(32'h4348_0000);
      chk("rf2_ref",   {31'd0, refractory},   32'd0);
      chk("rf2_pot",   potential,             32'h0);
      send(32'h4348_0000);
      repeat (2) @(negedge clk);
      chk("rf3_pot3",  potential,             32'h4348_0000);
      @(negedge clk);
      chk("rf3_sv",    {31'd0, spike_valid},  32'd1);
      chk("rf3_pot",   potential,             32'h0);
      @(negedge clk);
      chk("rf3_done",  {31'd0, spike_valid},  32'd0);
      chk("rf3_ref",   {31'd0, refractory},   32'd1);
      chk("ovr_stick", {31'd0, overrun},      32'd1);

      // Burn refractory, then negative potentials
      send(32'h0);
      send(32'h0);
      chk("neg_ref0",  {31'd0, refractory},   32'd0);
      send(32'hC1A0_0000);
      repeat (2) @(negedge clk);
      chk("neg_pot",   potential,             32'hC1A0_0000);
      @(negedge clk);
      chk("neg_sv",    {31'd0, spike_valid},  32'd0);
      send(32'h0);
      repeat (2) @(negedge clk);
      chk("leak_pot",  potential,             32'hC18C_0000);
      @(negedge clk);
      chk("leak_sv",   {31'd0, spike_valid},  32'd0);

      // -17.5 -> -15.3125 + 200 = 184.6875 fires; reset while spike pending
      spike_ready = 1'b0;
      send(32'h4348_0000);
      repeat (2) @(negedge clk);
      chk("e_pot3",    potential,             32'h4338_B000);
      @(negedge clk);
      chk("e_sv",      {31'd0, spike_valid},  32'd1);
      rst = 1'b1; sum_valid = 1'b1; sum_in = 32'h4348_0000;
      @(negedge clk);
      rst = 1'b0; sum_valid = 1'b0;
      chk("er_sv",     {31'd0, spike_valid},  32'd0);
      chk("er_addr",   {20'd0, spike_address},32'd0);
      chk("er_pot",    potential,             32'h0);
      chk("er_rdy",    {31'd0, sum_ready},    32'd1);
      chk("er_ovr",    {31'd0, overrun},      32'd0);
      chk("er_ref",    {31'd0, refractory},   32'd0);
      @(negedge clk);
      chk("er_idle",   {31'd0, sum_ready},    32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
